// File: rtl/fp_adder_pkg.sv
// Shared constants and FSM encoding for the arbitrated single-precision adder.
package fp_adder_pkg;
   localparam int FP_W = 32;

   localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
   localparam logic [FP_W-1:0] FP_HALF = 32'h3F00_0000;
   localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single adder, round-to-nearest-even, subnormals supported.
// Overflow: result rounds past max finite (returns inf). Underflow: tiny and inexact.
module fp_adder
   import fp_adder_pkg::*;
(
   input  logic [FP_W-1:0] i_a,
   input  logic [FP_W-1:0] i_b,
   output logic [FP_W-1:0] o_sum,
   output logic            o_overflow,
   output logic            o_underflow
);
   logic            w_swap, w_stk, w_rup, w_inexact;
   logic [FP_W-1:0] w_x, w_y;
   logic [7:0]      w_ex, w_ey, w_d;
   logic [26:0]     w_mx, w_my, w_sh, w_sm, w_n;
   logic [27:0]     w_s;
   logic [4:0]      w_lz;
   logic [9:0]      w_e, w_shl;
   logic [24:0]     w_m;

   always_comb begin
      // x always carries the larger magnitude, so its sign is the result sign
      w_swap = (i_b[30:0] > i_a[30:0]);
      w_x    = w_swap ? i_b : i_a;
      w_y    = w_swap ? i_a : i_b;
      w_ex   = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
      w_ey   = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
      w_d    = w_ex - w_ey;
      w_mx   = {(w_x[30:23] != 8'd0), w_x[22:0], 3'b000};
      w_my   = {(w_y[30:23] != 8'd0), w_y[22:0], 3'b000};
      w_sh   = (w_d > 8'd26) ? 27'd0 : (w_my >> w_d);
      w_stk  = (w_d > 8'd26) ? (|w_my) : (|(w_my & ~({27{1'b1}} << w_d)));
      w_sm   = {w_sh[26:1], w_sh[0] | w_stk};
      w_s    = (w_x[31] == w_y[31]) ? ({1'b0, w_mx} + {1'b0, w_sm})
                                    : ({1'b0, w_mx} - {1'b0, w_sm});

      w_lz = 5'd27;
      for (int k = 0; k < 27; k++) begin
         if (w_s[k]) w_lz = 5'(26 - k);
      end

      w_e   = {2'b00, w_ex};
      w_shl = '0;
      if (w_s[27]) begin
         w_n = {w_s[27:2], w_s[1] | w_s[0]};
         w_e = w_e + 10'd1;
      end else begin
         // left shift stops at exponent 1 so small results land as subnormals
         w_shl = ({5'd0, w_lz} < (w_e - 10'd1)) ? {5'd0, w_lz} : (w_e - 10'd1);
         w_n   = w_s[26:0] << w_shl;
         w_e   = w_e - w_shl;
      end

      w_inexact = |w_n[2:0];
      w_rup     = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
      w_m       = {1'b0, w_n[26:3]} + {24'd0, w_rup};
      if (w_m[24]) begin
         w_m = w_m >> 1;
         w_e = w_e + 10'd1;
      end

      o_sum       = {w_x[31], (w_m[23] ? w_e[7:0] : 8'd0), w_m[22:0]};
      o_overflow  = 1'b0;
      o_underflow = ~w_m[23] & w_inexact;
      if (w_e >= 10'd255) begin
         o_sum       = {w_x[31], 8'hFF, 23'd0};
         o_overflow  = 1'b1;
         o_underflow = 1'b0;
      end
      if (w_s == 28'd0) o_sum = {w_x[31] & w_y[31], 31'd0};

      if (w_x[30:23] == 8'hFF) begin
         o_overflow  = 1'b0;
         o_underflow = 1'b0;
         if (w_x[22:0] != 23'd0)
            o_sum = w_x | 32'h0040_0000;
         else if ((w_y[30:0] == w_x[30:0]) && (w_y[31] != w_x[31]))
            o_sum = FP_QNAN;
         else
            o_sum = w_x;
      end
   end
endmodule

// File: rtl/fp_adder_arbiter_rr.sv
// Round-robin pick: first asserted request searching cyclically upward from i_ptr.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [PTR_W-1:0]   o_idx
);
   int w_idx;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_idx   = 0;
      // scan farthest-first so the closest hit to i_ptr wins
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = (int'(i_ptr) + k) % NUM_REQ;
         if (i_en && i_req[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            o_idx          = PTR_W'(w_idx);
         end
      end
   end
endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one fp_adder between NUM_REQ clients; operands and results are both registered.
module fp_adder_arbiter
   import fp_adder_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_REQ-1:0]      i_req_valid,
   input  logic [NUM_REQ*FP_W-1:0] i_req_a,
   input  logic [NUM_REQ*FP_W-1:0] i_req_b,
   output logic [NUM_REQ-1:0]      o_req_ready,
   output logic [NUM_REQ-1:0]      o_resp_valid,
   input  logic [NUM_REQ-1:0]      i_resp_ready,
   output logic [FP_W-1:0]         o_resp_sum,
   output logic                    o_resp_overflow,
   output logic                    o_resp_underflow,
   output logic                    o_busy
);
   localparam int PTR_W = $clog2(NUM_REQ);

   state_t             r_state, w_state_nxt;
   logic [PTR_W-1:0]   r_rr_ptr, r_owner, w_gidx;
   logic [FP_W-1:0]    r_op_a, r_op_b, w_sel_a, w_sel_b, w_sum;
   logic [FP_W-1:0]    r_resp_sum;
   logic [NUM_REQ-1:0] r_resp_valid, w_grant;
   logic               r_resp_ovf, r_resp_unf, w_ovf, w_unf;
   logic               w_resp_hs, w_arb_en, w_req_hs;

   // a new grant is only offered when the datapath is free or being freed this cycle
   assign w_resp_hs = (r_state == HOLD) && i_resp_ready[r_owner];
   assign w_arb_en  = (r_state == IDLE) || w_resp_hs;
   assign w_req_hs  = |w_grant;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .i_en    (w_arb_en),
      .o_grant (w_grant),
      .o_idx   (w_gidx)
   );

   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_a = i_req_a[i*FP_W +: FP_W];
            w_sel_b = i_req_b[i*FP_W +: FP_W];
         end
      end
   end

   fp_adder u_add (
      .i_a         (r_op_a),
      .i_b         (r_op_b),
      .o_sum       (w_sum),
      .o_overflow  (w_ovf),
      .o_underflow (w_unf)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req_hs) w_state_nxt = CALC;
         CALC:    w_state_nxt = HOLD;
         HOLD:    if (w_resp_hs) w_state_nxt = w_req_hs ? CALC : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_owner      <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_resp_valid <= '0;
         r_resp_sum   <= '0;
         r_resp_ovf   <= 1'b0;
         r_resp_unf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_req_hs) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_owner  <= w_gidx;
            r_rr_ptr <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
         end
         if (r_state == CALC) begin
            r_resp_sum   <= w_sum;
            r_resp_ovf   <= w_ovf;
            r_resp_unf   <= w_unf;
            r_resp_valid <= NUM_REQ'(1) << r_owner;
         end else if (w_resp_hs) begin
            r_resp_valid <= '0;
         end
      end
   end

   assign o_req_ready      = w_grant;
   assign o_resp_valid     = r_resp_valid;
   assign o_resp_sum       = r_resp_sum;
   assign o_resp_overflow  = r_resp_ovf;
   assign o_resp_underflow = r_resp_unf;
   assign o_busy           = (r_state != IDLE);
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: grant order, latency, hold, reset abort, FP corners.
module tb_fp_adder_arbiter;
   import fp_adder_pkg::*;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*32-1:0] req_a = '0;
   logic [N*32-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   resp_valid;
   logic [N-1:0]   resp_ready = '0;
   logic [31:0]    resp_sum;
   logic           ovf, unf, busy;

   int checks = 0;
   int errors = 0;

   fp_adder_arbiter #(.NUM_REQ(N)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_req_valid      (req_valid),
      .i_req_a          (req_a),
      .i_req_b          (req_b),
      .o_req_ready      (req_ready),
      .o_resp_valid     (resp_valid),
      .i_resp_ready     (resp_ready),
      .o_resp_sum       (resp_sum),
      .o_resp_overflow  (ovf),
      .o_resp_underflow (unf),
      .o_busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
   endtask

   task automatic do_reset();
      req_valid  = '0;
      resp_ready = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
      checks++; if (resp_sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 00000000", resp_sum); end
      checks++; if ({ovf, unf, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags_busy: got %b want 000", {ovf, unf, busy}); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_op(0, FP_ONE, FP_HALF);
      req_valid = 4'b0001; resp_ready = 4'b0000; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      tick(); req_valid = '0;
      checks++; if (resp_valid !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_calc: got valid=%b busy=%b want 0000/1", resp_valid, busy); end
      tick();
      checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_latency: got %b want 0001", resp_valid); end
      checks++; if ({resp_sum, ovf, unf} !== {32'h3FC00000, 2'b00}) begin errors++; $display("FAIL single_sum: got %h/%b%b want 3fc00000/00", resp_sum, ovf, unf); end
      resp_ready = 4'b0001;
      tick();
      checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got valid=%b busy=%b want 0000/0", resp_valid, busy); end
   endtask

   task automatic test_round_robin();
      int          order [5] = '{0, 1, 2, 3, 0};
      logic [31:0] exps  [4] = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h40400000};
      logic [3:0]  oh;
      int          g;
      do_reset();
      set_op(0, FP_ONE, FP_ONE);
      set_op(1, FP_ONE, FP_HALF);
      set_op(2, FP_HALF, FP_HALF);
      set_op(3, 32'h40000000, FP_ONE);
      req_valid = 4'hF; resp_ready = 4'hF; #1;
      for (int k = 0; k < 5; k++) begin
         g  = order[k];
         oh = 4'(1 << g);
         checks++; if (req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, oh); end
         tick();
         checks++; if (req_ready !== 4'b0000 || resp_valid !== 4'b0000) begin errors++; $display("FAIL rr_calc%0d: got ready=%b valid=%b want 0000/0000", k, req_ready, resp_valid); end
         if (k == 4) req_valid = '0;
         tick();
         checks++; if (resp_valid !== oh || resp_sum !== exps[g]) begin errors++; $display("FAIL rr_resp%0d: got %b/%h want %b/%h", k, resp_valid, resp_sum, oh, exps[g]); end
      end
      tick();
      checks++; if (busy !== 1'b0 || resp_valid !== 4'b0000) begin errors++; $display("FAIL rr_idle: got busy=%b valid=%b want 0/0000", busy, resp_valid); end
   endtask

   task automatic test_hold();
      set_op(2, 32'hBE800000, 32'h3E000000);
      req_valid = 4'b0100; resp_ready = 4'b0000; #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hold_grant: got %b want 0100", req_ready); end
      tick(); req_valid = '0;
      tick();
      req_valid = 4'hF; resp_ready = 4'b1011; #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (resp_valid !== 4'b0100 || resp_sum !== 32'hBE000000 || busy !== 1'b1 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL hold_cycle%0d: got valid=%b sum=%h busy=%b ready=%b want 0100/be000000/1/0000", c, resp_valid, resp_sum, busy, req_ready);
         end
         tick();
      end
      req_valid = '0; resp_ready = 4'b0100;
      tick();
      checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL hold_release: got valid=%b busy=%b want 0000/0", resp_valid, busy); end
   endtask

   task automatic test_reset_mid();
      set_op(0, FP_ONE, FP_ONE);
      set_op(1, FP_ONE, 32'hBF000000);
      resp_ready = 4'hF;
      req_valid = 4'b0010; #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_grant: got %b want 0010", req_ready); end
      tick(); req_valid = '0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_calc: got busy=%b want 1", busy); end
      rst = 1'b1; #1;
      checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0 || resp_sum !== 32'h0) begin errors++; $display("FAIL rstmid_async: got valid=%b busy=%b sum=%h want 0000/0/00000000", resp_valid, busy, resp_sum); end
      tick(); rst = 1'b0;
      tick(); tick();
      checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_resp: got valid=%b busy=%b want 0000/0", resp_valid, busy); end
      req_valid = 4'b0011; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr0: got %b want 0001", req_ready); end
      req_valid = '0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_before_grant: got busy=%b want 0", busy); end
   endtask

   task automatic test_fp_corners();
      set_op(0, 32'h00000001, 32'h00000001);
      set_op(1, 32'h7F5FFFFE, 32'h7F5FFFFF);
      resp_ready = 4'hF;
      req_valid = 4'b0001; #1;
      tick(); req_valid = '0;
      tick();
      checks++; if (resp_valid !== 4'b0001 || {resp_sum, ovf, unf} !== {32'h00000002, 2'b00}) begin errors++; $display("FAIL denorm_sum: got %b/%h/%b%b want 0001/00000002/00", resp_valid, resp_sum, ovf, unf); end
      req_valid = 4'b0010; #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_grant: got %b want 0010", req_ready); end
      tick(); req_valid = '0;
      tick();
      checks++; if (resp_valid !== 4'b0010 || {resp_sum, ovf, unf} !== {32'h7F800000, 2'b10}) begin errors++; $display("FAIL overflow: got %b/%h/%b%b want 0010/7f800000/10", resp_valid, resp_sum, ovf, unf); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL corners_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_no_starvation();
      logic [3:0]  oh;
      logic [31:0] exp_sum;
      set_op(0, FP_ONE, FP_ONE);
      set_op(3, FP_HALF, FP_HALF);
      resp_ready = 4'hF;
      for (int k = 0; k < 6; k++) begin
         oh      = (k % 2 == 0) ? 4'b1000 : 4'b0001;
         exp_sum = (k % 2 == 0) ? 32'h3F800000 : 32'h40000000;
         req_valid = 4'b1001; #1;
         checks++; if (req_ready !== oh) begin errors++; $display("FAIL starve_grant%0d: got %b want %b", k, req_ready, oh); end
         tick();
         req_valid = (k == 5) ? 4'b0000 : 4'b0001;
         tick();
         checks++; if (resp_valid !== oh || resp_sum !== exp_sum) begin errors++; $display("FAIL starve_resp%0d: got %b/%h want %b/%h", k, resp_valid, resp_sum, oh, exp_sum); end
      end
      req_valid = '0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_idle: got busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_hold();
      test_reset_mid();
      test_fp_corners();
      test_no_starvation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
